semaforo_n: RTL and testbench
=============================

SEMAFORO_N -- requirements
Module: semaforo_n

Interface
REQ-001 SHALL provide parameter N_WAYS, default 2, number of traffic ways served round-robin (legal 2..8).
REQ-002 SHALL provide parameter CW, default 8, width of the phase counter.
REQ-003 SHALL provide parameters T_GREEN=3, T_YELLOW=1, T_ALLRED=1, T_WALK=2, T_MIN_GREEN=1, giving phase durations in clock cycles (legal 1..2^CW-1, T_MIN_GREEN <= T_GREEN).
REQ-004 SHALL provide port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL provide port: rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port: bt  input  1  pedestrian request button, sampled on clk.
REQ-007 SHALL provide port: flash  input  1  night mode request, level-sensitive, sampled on clk.
REQ-008 SHALL provide port: lights  output  3*N_WAYS  per-way lamp state, way k at [3k+2:3k], one-hot 001=green, 010=yellow, 100=red, 000=dark.
REQ-009 SHALL provide port: walk  output  1  pedestrian walk lamp.
REQ-010 SHALL provide port: way  output  3  index of the way owning the current green/yellow phase.
REQ-011 SHALL provide port: req_pending  output  1  latched pedestrian request.

Function
REQ-012 SHALL implement FSM states GREEN, YELLOW, ALLRED, WALK, FLASH; all outputs registered or decoded from registered state only.
REQ-013 SHALL clear the phase counter cnt to 0 on every state entry and increment it each cycle otherwise.
REQ-014 GREEN SHALL exit to YELLOW when cnt==T_GREEN-1, or earlier when req_pending==1 and cnt>=T_MIN_GREEN-1.
REQ-015 YELLOW SHALL exit to ALLRED when cnt==T_YELLOW-1.
REQ-016 ALLRED SHALL exit when cnt==T_ALLRED-1: to WALK if req_pending==1, else to GREEN with way=(way+1) mod N_WAYS.
REQ-017 WALK SHALL exit to GREEN with way=(way+1) mod N_WAYS when cnt==T_WALK-1.
REQ-018 req_pending SHALL set on any clock edge with bt==1 while not in WALK, and clear on the edge entering WALK; bt during WALK is ignored; set wins only outside WALK.
REQ-019 In GREEN/YELLOW the owning way SHALL show green/yellow and all other ways red; in ALLRED and WALK all ways SHALL show red.
REQ-020 walk SHALL be 1 only in WALK.
REQ-021 flash==1 sampled on any edge SHALL force FLASH next cycle from any state, overriding all other transitions, and set way=N_WAYS-1.
REQ-022 In FLASH all ways SHALL show yellow on the first cycle and alternate yellow/dark each cycle; walk=0; req_pending held.
REQ-023 flash==0 sampled in FLASH SHALL move to ALLRED, after which normal rotation resumes at way 0.
REQ-024 Counter SHALL never wrap in normal operation; comparisons use CW-bit unsigned arithmetic.

Reset
REQ-025 rst==0 SHALL immediately, without clock, force state GREEN, way=0, cnt=0, req_pending=0, walk=0, lights=way 0 green, all others red.
REQ-026 Release of rst SHALL start GREEN cnt counting from the first rising edge with rst==1.
REQ-027 Reset asserted mid-phase (including FLASH or WALK) SHALL discard the phase and any pending request.

Verification (defaults unless stated)
REQ-028 Reset then idle: lights 100_001 for 3 cycles, 100_010 1 cycle, 100_100 1 cycle, 001_100 3 cycles, 010_100, 100_100, then 100_001 again; walk stays 0.
REQ-029 bt pulsed 1 cycle at GREEN cnt=0: req_pending=1 next cycle, YELLOW entered after 2 green cycles, ALLRED 1 cycle, WALK 2 cycles with walk=1 and lights 100_100, then way 1 green, req_pending=0.
REQ-030 bt held high through WALK: req_pending stays 0 during WALK, re-asserts on first edge in following GREEN.
REQ-031 flash raised during way 0 GREEN: next cycles lights 010_010, 000_000, 010_010...; flash dropped -> 1 cycle 100_100 -> 100_001 with way=0.
REQ-032 rst driven low mid-YELLOW between edges: outputs return to reset values combinationally before next edge.
REQ-033 N_WAYS=3: way sequence 0,1,2,0 with each lights field green exactly 3 cycles per rotation absent bt.

Source files
------------

// File: rtl/semaforo_n.sv
// Round-robin traffic light controller for N_WAYS ways, with a pedestrian walk phase and a night flash mode.
// All outputs are registered from the next-state decode. The async active-low reset loads the way 0 green image.
module semaforo_n #(
  parameter int unsigned N_WAYS      = 2,
  parameter int unsigned CW          = 8,
  parameter int unsigned T_GREEN     = 3,
  parameter int unsigned T_YELLOW    = 1,
  parameter int unsigned T_ALLRED    = 1,
  parameter int unsigned T_WALK      = 2,
  parameter int unsigned T_MIN_GREEN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bt,
  input  logic                  flash,
  output logic [3*N_WAYS-1:0]   lights,
  output logic                  walk,
  output logic [2:0]            way,
  output logic                  req_pending
);

  localparam int unsigned LW = 3 * N_WAYS;

  localparam logic [CW-1:0] GREEN_END  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] YELLOW_END = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] ALLRED_END = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] WALK_END   = CW'(T_WALK - 1);
  localparam logic [CW-1:0] MIN_GREEN  = CW'(T_MIN_GREEN);
  localparam logic [2:0]    LAST_WAY   = 3'(N_WAYS - 1);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_D = 3'b000;

  typedef enum logic [2:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_WALK,
    S_FLASH
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_way;
  logic            r_req;
  logic            r_blink;
  logic [LW-1:0]   r_lights;
  logic            r_walk;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      w_way_nxt;
  logic            w_req_nxt;
  logic            w_blink_nxt;
  logic [2:0]      w_way_inc;

  // Lamp image for a given phase; blink selects the dark half of the flash cycle.
  function automatic logic [LW-1:0] lamps(input state_t s, input logic [2:0] w, input logic blink);
    logic [LW-1:0] v;
    logic [2:0]    lamp;
    v = '0;
    for (int unsigned k = 0; k < N_WAYS; k++) begin
      case (s)
        S_GREEN:  lamp = (3'(k) == w) ? LAMP_G : LAMP_R;
        S_YELLOW: lamp = (3'(k) == w) ? LAMP_Y : LAMP_R;
        S_FLASH:  lamp = blink ? LAMP_D : LAMP_Y;
        default:  lamp = LAMP_R;
      endcase
      v[3*k +: 3] = lamp;
    end
    return v;
  endfunction

  assign w_way_inc = (r_way == LAST_WAY) ? 3'd0 : r_way + 3'd1;

  // Next-state, counter, way and request decode.
  always_comb begin
    w_state_nxt = r_state;
    w_way_nxt   = r_way;
    w_req_nxt   = r_req;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_blink_nxt = 1'b0;

    if (r_state != S_WALK && bt) w_req_nxt = 1'b1;

    if (flash) begin
      w_state_nxt = S_FLASH;
      w_way_nxt   = LAST_WAY;
    end else begin
      case (r_state)
        S_GREEN:
          if (r_cnt == GREEN_END || (r_req && (r_cnt + CW'(1)) >= MIN_GREEN))
            w_state_nxt = S_YELLOW;
        S_YELLOW:
          if (r_cnt == YELLOW_END) w_state_nxt = S_ALLRED;
        S_ALLRED:
          if (r_cnt == ALLRED_END) begin
            if (r_req) begin
              w_state_nxt = S_WALK;
            end else begin
              w_state_nxt = S_GREEN;
              w_way_nxt   = w_way_inc;
            end
          end
        S_WALK:
          if (r_cnt == WALK_END) begin
            w_state_nxt = S_GREEN;
            w_way_nxt   = w_way_inc;
          end
        S_FLASH:
          w_state_nxt = S_ALLRED;
        default:
          w_state_nxt = S_GREEN;
      endcase
    end

    // Entering WALK consumes the request even if bt is still held.
    if (w_state_nxt == S_WALK && r_state != S_WALK) w_req_nxt = 1'b0;

    // Flash has no timed exit, so its counter is frozen rather than left to wrap.
    if (w_state_nxt != r_state)   w_cnt_nxt = '0;
    else if (r_state == S_FLASH)  w_cnt_nxt = r_cnt;

    if (r_state == S_FLASH && w_state_nxt == S_FLASH) w_blink_nxt = ~r_blink;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_GREEN;
      r_cnt    <= '0;
      r_way    <= 3'd0;
      r_req    <= 1'b0;
      r_blink  <= 1'b0;
      r_lights <= lamps(S_GREEN, 3'd0, 1'b0);
      r_walk   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_way    <= w_way_nxt;
      r_req    <= w_req_nxt;
      r_blink  <= w_blink_nxt;
      r_lights <= lamps(w_state_nxt, w_way_nxt, w_blink_nxt);
      r_walk   <= (w_state_nxt == S_WALK);
    end
  end

  assign lights      = r_lights;
  assign walk        = r_walk;
  assign way         = r_way;
  assign req_pending = r_req;

endmodule

// File: tb/tb_semaforo_n.sv
// Directed scoreboard bench for semaforo_n: a 2-way instance covers the main sequences,
// and a 3-way instance covers the rotation.
module tb_semaforo_n;

  logic       clk = 1'b0;
  logic       rst, bt, flash;
  logic [5:0] lights;
  logic       walk;
  logic [2:0] way;
  logic       req_pending;

  logic       rst3;
  logic [8:0] lights3;
  logic       walk3;
  logic [2:0] way3;
  logic       req3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  semaforo_n u_dut (
    .clk(clk), .rst(rst), .bt(bt), .flash(flash),
    .lights(lights), .walk(walk), .way(way), .req_pending(req_pending)
  );

  semaforo_n #(.N_WAYS(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bt(1'b0), .flash(1'b0),
    .lights(lights3), .walk(walk3), .way(way3), .req_pending(req3)
  );

  typedef struct {
    string      tag;
    logic [8:0] lights;
    logic       walk;
    logic [2:0] way;
    logic       req;
  } exp_t;

  exp_t q[$];

  task automatic push_exp(input string tag, input logic [8:0] l, input logic w,
                          input logic [2:0] wy, input logic r);
    exp_t e;
    e.tag = tag; e.lights = l; e.walk = w; e.way = wy; e.req = r;
    q.push_back(e);
  endtask

  task automatic check_one(input logic [8:0] l, input logic w, input logic [2:0] wy, input logic r);
    exp_t e;
    e = q.pop_front();
    total++;
    assert (l === e.lights) else begin
      bad++; $error("FAIL %s lights got=%b exp=%b", e.tag, l, e.lights);
    end
    total++;
    assert (w === e.walk) else begin
      bad++; $error("FAIL %s walk got=%b exp=%b", e.tag, w, e.walk);
    end
    total++;
    assert (wy === e.way) else begin
      bad++; $error("FAIL %s way got=%0d exp=%0d", e.tag, wy, e.way);
    end
    total++;
    assert (r === e.req) else begin
      bad++; $error("FAIL %s req_pending got=%b exp=%b", e.tag, r, e.req);
    end
  endtask

  // Drive inputs, expect the outputs that follow the next rising edge.
  task automatic step(input logic b, input logic f, input string tag, input logic [5:0] l,
                      input logic w, input logic [2:0] wy, input logic r);
    bt = b; flash = f;
    push_exp(tag, {3'b000, l}, w, wy, r);
    @(posedge clk); #1;
    check_one({3'b000, lights}, walk, way, req_pending);
  endtask

  // Check the 2-way instance now, without waiting for an edge.
  task automatic now_chk(input string tag, input logic [5:0] l, input logic w,
                         input logic [2:0] wy, input logic r);
    push_exp(tag, {3'b000, l}, w, wy, r);
    check_one({3'b000, lights}, walk, way, req_pending);
  endtask

  task automatic step3(input string tag, input logic [8:0] l, input logic [2:0] wy);
    push_exp(tag, l, 1'b0, wy, 1'b0);
    @(posedge clk); #1;
    check_one(lights3, walk3, way3, req3);
  endtask

  initial begin
    rst = 1'b0; rst3 = 1'b0; bt = 1'b0; flash = 1'b0;
    #12;
    now_chk("reset", 6'b100_001, 1'b0, 3'd0, 1'b0);
    push_exp("reset3", 9'b100_100_001, 1'b0, 3'd0, 1'b0);
    check_one(lights3, walk3, way3, req3);
    @(negedge clk) rst = 1'b1;

    // Idle rotation
    step(0, 0, "idle_g0a", 6'b100_001, 0, 3'd0, 0);
    step(0, 0, "idle_g0b", 6'b100_001, 0, 3'd0, 0);
    step(0, 0, "idle_y0",  6'b100_010, 0, 3'd0, 0);
    step(0, 0, "idle_ar0", 6'b100_100, 0, 3'd0, 0);
    step(0, 0, "idle_g1a", 6'b001_100, 0, 3'd1, 0);
    step(0, 0, "idle_g1b", 6'b001_100, 0, 3'd1, 0);
    step(0, 0, "idle_g1c", 6'b001_100, 0, 3'd1, 0);
    step(0, 0, "idle_y1",  6'b010_100, 0, 3'd1, 0);
    step(0, 0, "idle_ar1", 6'b100_100, 0, 3'd1, 0);
    step(0, 0, "idle_g0",  6'b100_001, 0, 3'd0, 0);

    // Single bt pulse at green cnt=0
    step(1, 0, "bt_g0",    6'b100_001, 0, 3'd0, 1);
    step(0, 0, "bt_y0",    6'b100_010, 0, 3'd0, 1);
    step(0, 0, "bt_ar0",   6'b100_100, 0, 3'd0, 1);
    step(0, 0, "bt_walka", 6'b100_100, 1, 3'd0, 0);
    step(0, 0, "bt_walkb", 6'b100_100, 1, 3'd0, 0);
    step(0, 0, "bt_g1",    6'b001_100, 0, 3'd1, 0);

    // bt held through WALK
    step(1, 0, "hold_g1",    6'b001_100, 0, 3'd1, 1);
    step(1, 0, "hold_y1",    6'b010_100, 0, 3'd1, 1);
    step(1, 0, "hold_ar1",   6'b100_100, 0, 3'd1, 1);
    step(1, 0, "hold_walka", 6'b100_100, 1, 3'd1, 0);
    step(1, 0, "hold_walkb", 6'b100_100, 1, 3'd1, 0);
    step(1, 0, "hold_g0a",   6'b100_001, 0, 3'd0, 0);
    step(1, 0, "hold_g0b",   6'b100_001, 0, 3'd0, 1);
    step(0, 0, "hold_y0",    6'b100_010, 0, 3'd0, 1);
    step(0, 0, "hold_ar0",   6'b100_100, 0, 3'd0, 1);
    step(0, 0, "hold_walkc", 6'b100_100, 1, 3'd0, 0);
    step(0, 0, "hold_walkd", 6'b100_100, 1, 3'd0, 0);
    step(0, 0, "hold_g1a",   6'b001_100, 0, 3'd1, 0);
    step(0, 0, "hold_g1b",   6'b001_100, 0, 3'd1, 0);
    step(0, 0, "hold_g1c",   6'b001_100, 0, 3'd1, 0);
    step(0, 0, "hold_y1b",   6'b010_100, 0, 3'd1, 0);
    step(0, 0, "hold_ar1b",  6'b100_100, 0, 3'd1, 0);
    step(0, 0, "hold_g0c",   6'b100_001, 0, 3'd0, 0);

    // Flash mode during way 0 green
    step(0, 1, "flash_y",   6'b010_010, 0, 3'd1, 0);
    step(0, 1, "flash_d",   6'b000_000, 0, 3'd1, 0);
    step(0, 1, "flash_y2",  6'b010_010, 0, 3'd1, 0);
    step(0, 0, "flash_ar",  6'b100_100, 0, 3'd1, 0);
    step(0, 0, "flash_g0a", 6'b100_001, 0, 3'd0, 0);
    step(0, 0, "flash_g0b", 6'b100_001, 0, 3'd0, 0);
    step(0, 0, "flash_g0c", 6'b100_001, 0, 3'd0, 0);
    step(0, 0, "pre_rst_y", 6'b100_010, 0, 3'd0, 0);

    // Asynchronous reset mid-yellow
    #2 rst = 1'b0;
    #1 now_chk("async_rst_y", 6'b100_001, 0, 3'd0, 0);
    @(negedge clk) rst = 1'b1;

    // Pending request held into flash, then reset mid-flash discards it
    step(1, 0, "rf_g0",    6'b100_001, 0, 3'd0, 1);
    step(0, 1, "rf_flash", 6'b010_010, 0, 3'd1, 1);
    #2 rst = 1'b0; flash = 1'b0;
    #1 now_chk("async_rst_f", 6'b100_001, 0, 3'd0, 0);
    @(negedge clk) rst = 1'b1;
    step(0, 0, "post_g0a", 6'b100_001, 0, 3'd0, 0);
    step(0, 0, "post_g0b", 6'b100_001, 0, 3'd0, 0);
    step(0, 0, "post_y0",  6'b100_010, 0, 3'd0, 0);

    // Three-way rotation
    @(negedge clk) rst3 = 1'b1;
    step3("w3_g0a", 9'b100_100_001, 3'd0);
    step3("w3_g0b", 9'b100_100_001, 3'd0);
    step3("w3_y0",  9'b100_100_010, 3'd0);
    step3("w3_ar0", 9'b100_100_100, 3'd0);
    step3("w3_g1a", 9'b100_001_100, 3'd1);
    step3("w3_g1b", 9'b100_001_100, 3'd1);
    step3("w3_g1c", 9'b100_001_100, 3'd1);
    step3("w3_y1",  9'b100_010_100, 3'd1);
    step3("w3_ar1", 9'b100_100_100, 3'd1);
    step3("w3_g2a", 9'b001_100_100, 3'd2);
    step3("w3_g2b", 9'b001_100_100, 3'd2);
    step3("w3_g2c", 9'b001_100_100, 3'd2);
    step3("w3_y2",  9'b010_100_100, 3'd2);
    step3("w3_ar2", 9'b100_100_100, 3'd2);
    step3("w3_g0c", 9'b100_100_001, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
